// File: rtl/usb_serial_fifo_bridge.sv
// usb_serial_fifo_bridge: byte FIFOs between a user stream and USB bulk IN/OUT endpoints with IN release batching.
module usb_serial_fifo_bridge #(
  parameter int TX_ASIZE     = 10,
  parameter int RX_ASIZE     = 6,
  parameter int FLUSH_THRESH = 32,
  parameter int IDLE_CYCLES  = 60000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                usb_rstn,
  input  logic                clr_stats,
  input  logic [7:0]          send_data,
  input  logic                send_valid,
  output logic                send_ready,
  output logic [7:0]          ep_in_data,
  output logic                ep_in_valid,
  input  logic                ep_in_ready,
  input  logic [7:0]          ep_out_data,
  input  logic                ep_out_valid,
  output logic [7:0]          recv_data,
  output logic                recv_valid,
  input  logic                recv_ready,
  output logic [TX_ASIZE:0]   tx_level,
  output logic [RX_ASIZE:0]   rx_level,
  output logic                rx_overflow,
  output logic [15:0]         rx_drop_cnt
);
  localparam int TX_DEPTH = 1 << TX_ASIZE;
  localparam int RX_DEPTH = 1 << RX_ASIZE;
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [1:0] EMPTY = 2'd0, ACCUM = 2'd1, RELEASE = 2'd2;
  logic flush;
  logic [7:0] tx_mem [TX_DEPTH];
  logic [7:0] rx_mem [RX_DEPTH];
  logic [TX_ASIZE:0] tx_wp, tx_rp;
  logic [RX_ASIZE:0] rx_wp, rx_rp;
  logic [1:0] state, state_nxt;
  logic [IW-1:0] idle_cnt;
  logic tx_wr, tx_cons, tx_load, thresh_hit, idle_hit;
  logic rx_full, rx_wr, rx_drop, rx_cons, rx_take, rx_ram_empty, rx_from_ram, rx_bypass;
  assign flush = rst || !usb_rstn;
  assign send_ready = usb_rstn && tx_level != (TX_ASIZE+1)'(TX_DEPTH);
  assign tx_wr = send_valid && send_ready;
  assign tx_cons = ep_in_valid && ep_in_ready;
  // The IN register only fills in RELEASE, so ep_in_valid is naturally low while accumulating.
  assign tx_load = state == RELEASE && tx_wp != tx_rp && (!ep_in_valid || ep_in_ready);
  assign thresh_hit = {1'b0, tx_level} + 1'b1 >= (TX_ASIZE+2)'(FLUSH_THRESH);
  assign idle_hit = idle_cnt == IW'(IDLE_CYCLES - 1);
  always_comb begin
    state_nxt = (state == RELEASE) ? ((tx_level == (TX_ASIZE+1)'(1) && tx_cons && !tx_wr) ? EMPTY : RELEASE)
              : tx_wr ? (thresh_hit ? RELEASE : ACCUM)
              : (state == ACCUM && idle_hit) ? RELEASE : state;
  end
  always_ff @(posedge clk)
    if (tx_wr) tx_mem[tx_wp[TX_ASIZE-1:0]] <= send_data;
  always_ff @(posedge clk) begin
    if (flush || tx_wr || state != ACCUM) idle_cnt <= '0;
    else if (!idle_hit) idle_cnt <= idle_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (flush) begin
      state <= EMPTY;
      tx_wp <= '0;
      tx_rp <= '0;
      tx_level <= '0;
      ep_in_valid <= 1'b0;
      ep_in_data <= 8'h00;
    end else begin
      state <= state_nxt;
      tx_level <= tx_level + (TX_ASIZE+1)'(tx_wr) - (TX_ASIZE+1)'(tx_cons);
      if (tx_wr) tx_wp <= tx_wp + 1'b1;
      if (tx_load) begin
        ep_in_data <= tx_mem[tx_rp[TX_ASIZE-1:0]];
        ep_in_valid <= 1'b1;
        tx_rp <= tx_rp + 1'b1;
      end else if (tx_cons) ep_in_valid <= 1'b0;
    end
  end
  assign rx_full = rx_level == (RX_ASIZE+1)'(RX_DEPTH);
  assign rx_wr = usb_rstn && ep_out_valid && !rx_full;
  assign rx_drop = usb_rstn && ep_out_valid && rx_full;
  assign rx_cons = recv_valid && recv_ready;
  assign rx_take = !recv_valid || rx_cons;
  assign rx_ram_empty = rx_wp == rx_rp;
  assign rx_from_ram = rx_take && !rx_ram_empty;
  // An OUT byte arriving to an empty stage skips the RAM, keeping recv_valid equal to rx_level != 0.
  assign rx_bypass = rx_take && rx_ram_empty && rx_wr;
  always_ff @(posedge clk)
    if (rx_wr && !rx_bypass) rx_mem[rx_wp[RX_ASIZE-1:0]] <= ep_out_data;
  always_ff @(posedge clk) begin
    if (flush) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_level <= '0;
      recv_valid <= 1'b0;
      recv_data <= 8'h00;
    end else begin
      rx_level <= rx_level + (RX_ASIZE+1)'(rx_wr) - (RX_ASIZE+1)'(rx_cons);
      if (rx_wr && !rx_bypass) rx_wp <= rx_wp + 1'b1;
      if (rx_from_ram) begin
        recv_data <= rx_mem[rx_rp[RX_ASIZE-1:0]];
        recv_valid <= 1'b1;
        rx_rp <= rx_rp + 1'b1;
      end else if (rx_bypass) begin
        recv_data <= ep_out_data;
        recv_valid <= 1'b1;
      end else if (rx_cons) recv_valid <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_overflow <= 1'b0;
      rx_drop_cnt <= 16'h0000;
    end else if (rx_drop) begin
      rx_overflow <= 1'b1;
      rx_drop_cnt <= clr_stats ? 16'h0001 : (rx_drop_cnt == 16'hFFFF) ? rx_drop_cnt : rx_drop_cnt + 1'b1;
    end else if (clr_stats) begin
      rx_overflow <= 1'b0;
      rx_drop_cnt <= 16'h0000;
    end
  end
endmodule

// File: tb/tb_usb_serial_fifo_bridge.sv
// tb_usb_serial_fifo_bridge: scoreboard bench for the USB serial FIFO bridge at default parameters.
module tb_usb_serial_fifo_bridge;
  logic clk = 1'b0, rst = 1'b1, usb_rstn = 1'b1, clr_stats = 1'b0;
  logic [7:0] send_data = 8'h00, ep_out_data = 8'h00;
  logic send_valid = 1'b0, ep_in_ready = 1'b0, ep_out_valid = 1'b0, recv_ready = 1'b0;
  logic send_ready, ep_in_valid, recv_valid, rx_overflow;
  logic [7:0] ep_in_data, recv_data;
  logic [10:0] tx_level;
  logic [6:0] rx_level;
  logic [15:0] rx_drop_cnt;
  int checks = 0, failures = 0;
  logic [7:0] tx_q[$], rx_q[$];
  always #5 clk = ~clk;
  usb_serial_fifo_bridge dut (
    .clk(clk), .rst(rst), .usb_rstn(usb_rstn), .clr_stats(clr_stats),
    .send_data(send_data), .send_valid(send_valid), .send_ready(send_ready),
    .ep_in_data(ep_in_data), .ep_in_valid(ep_in_valid), .ep_in_ready(ep_in_ready),
    .ep_out_data(ep_out_data), .ep_out_valid(ep_out_valid),
    .recv_data(recv_data), .recv_valid(recv_valid), .recv_ready(recv_ready),
    .tx_level(tx_level), .rx_level(rx_level),
    .rx_overflow(rx_overflow), .rx_drop_cnt(rx_drop_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Resolve the handshakes of the coming edge, then advance one cycle.
  task automatic tick();
    #1;
    if (ep_in_valid && ep_in_ready) begin
      if (tx_q.size() == 0) chk("in_extra", 1, 0);
      else chk("in_data", ep_in_data, tx_q.pop_front());
    end
    if (recv_valid && recv_ready) begin
      if (rx_q.size() == 0) chk("recv_extra", 1, 0);
      else chk("recv_data", recv_data, rx_q.pop_front());
    end
    if (send_valid && send_ready) tx_q.push_back(send_data);
    if (usb_rstn && ep_out_valid && rx_level < 7'd64) rx_q.push_back(ep_out_data);
    if (!usb_rstn) begin
      tx_q.delete();
      rx_q.delete();
    end
    @(negedge clk);
  endtask
  initial begin
    int n, lat;
    @(negedge clk);
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_in_valid", ep_in_valid, 0);
    chk("rst_recv_valid", recv_valid, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_overflow", rx_overflow, 0);
    chk("rst_drop_cnt", rx_drop_cnt, 0);
    chk("rst_in_data", ep_in_data, 0);
    chk("rst_recv_data", recv_data, 0);
    chk("rst_send_ready", send_ready, 1);
    ep_in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_valid = 1'b1;
      send_data = 8'(i + 1);
      tick();
    end
    send_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 59999; i++) begin
      if (ep_in_valid) n++;
      tick();
    end
    chk("idle_hold", n, 0);
    for (int i = 0; i < 20 && tx_q.size() > 0; i++) tick();
    chk("idle_release", tx_q.size(), 0);
    chk("idle_level", tx_level, 0);
    chk("idle_valid", ep_in_valid, 0);
    n = 0;
    for (int i = 0; i < 32; i++) begin
      send_valid = 1'b1;
      send_data = 8'(8'h80 + i);
      if (ep_in_valid) n++;
      tick();
    end
    send_valid = 1'b0;
    chk("thresh_early", n, 0);
    lat = 0;
    while (!ep_in_valid && lat < 5) begin
      tick();
      lat++;
    end
    chk("thresh_latency", lat <= 2, 1);
    n = 0;
    while (tx_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("thresh_b2b", n, 32);
    chk("thresh_level", tx_level, 0);
    ep_in_ready = 1'b0;
    n = 0;
    for (int i = 0; i < 1100; i++) begin
      send_valid = 1'b1;
      send_data = 8'(i * 7);
      #1;
      if (!send_ready) break;
      n++;
      tick();
    end
    send_valid = 1'b0;
    chk("fill_count", n, 1024);
    chk("fill_level", tx_level, 1024);
    chk("fill_ready", send_ready, 0);
    ep_in_ready = 1'b1;
    n = 0;
    while (tx_q.size() > 0 && n < 1100) begin
      tick();
      n++;
    end
    chk("fill_drain", tx_q.size(), 0);
    chk("fill_drain_level", tx_level, 0);
    recv_ready = 1'b0;
    for (int i = 0; i < 70; i++) begin
      ep_out_valid = 1'b1;
      ep_out_data = 8'(8'h40 + i);
      tick();
    end
    ep_out_valid = 1'b0;
    tick();
    chk("rx_level_full", rx_level, 64);
    chk("rx_overflow", rx_overflow, 1);
    chk("rx_drop_cnt", rx_drop_cnt, 6);
    chk("rx_queued", rx_q.size(), 64);
    recv_ready = 1'b1;
    n = 0;
    while (rx_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("rx_drain", rx_q.size(), 0);
    chk("rx_drain_level", rx_level, 0);
    chk("rx_drain_valid", recv_valid, 0);
    ep_in_ready = 1'b0;
    for (int i = 0; i < 32; i++) begin
      send_valid = 1'b1;
      send_data = 8'(8'hC0 + i);
      tick();
    end
    send_valid = 1'b0;
    tick();
    ep_in_ready = 1'b1;
    repeat (12) tick();
    chk("mid_level", tx_level, 20);
    ep_in_ready = 1'b0;
    usb_rstn = 1'b0;
    #1;
    chk("disc_ready", send_ready, 0);
    tick();
    usb_rstn = 1'b1;
    chk("disc_level", tx_level, 0);
    chk("disc_valid", ep_in_valid, 0);
    chk("disc_drop_cnt", rx_drop_cnt, 6);
    chk("disc_overflow", rx_overflow, 1);
    ep_in_ready = 1'b1;
    n = 0;
    repeat (5) begin
      if (ep_in_valid) n++;
      tick();
    end
    chk("flush_clean", n, 0);
    recv_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ep_out_valid = 1'b1;
      ep_out_data = 8'(i * 3);
      tick();
    end
    clr_stats = 1'b1;
    tick();
    ep_out_valid = 1'b0;
    clr_stats = 1'b0;
    chk("clr_drop_overflow", rx_overflow, 1);
    chk("clr_drop_cnt", rx_drop_cnt, 1);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_overflow", rx_overflow, 0);
    chk("clr_cnt", rx_drop_cnt, 0);
    recv_ready = 1'b1;
    n = 0;
    while (rx_q.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("clr_rx_drain", rx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/usb_serial_fifo_bridge.md
USB_SERIAL_FIFO_BRIDGE -- requirements
Module: usb_serial_fifo_bridge

Interface
REQ-001 The block SHALL have parameter TX_ASIZE, default 10, meaning a send FIFO of 2^TX_ASIZE bytes.
REQ-002 The block SHALL have parameter RX_ASIZE, default 6, meaning a receive FIFO of 2^RX_ASIZE bytes.
REQ-003 The block SHALL have parameter FLUSH_THRESH, default 32, meaning the send-FIFO level that forces release to the IN endpoint (legal range 1..2^TX_ASIZE).
REQ-004 The block SHALL have parameter IDLE_CYCLES, default 60000, meaning the cycles without a send write after which buffered bytes are released (1 ms at 60 MHz; minimum 1).
REQ-005 The block SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-006 The block SHALL have port rst, input, 1, the synchronous active-high reset.
REQ-007 The block SHALL have port usb_rstn, input, 1, USB link status; 0 means disconnected.
REQ-008 The block SHALL have port clr_stats, input, 1, a one-cycle pulse clearing the overflow statistics.
REQ-009 The block SHALL have ports send_data (input, 8), send_valid (input, 1) and send_ready (output, 1), the user device-to-host byte stream.
REQ-010 The block SHALL have ports ep_in_data (output, 8), ep_in_valid (output, 1) and ep_in_ready (input, 1), which drive the bulk-IN endpoint.
REQ-011 The block SHALL have ports ep_out_data (input, 8) and ep_out_valid (input, 1), the bulk-OUT endpoint byte stream, which has no backpressure.
REQ-012 The block SHALL have ports recv_data (output, 8), recv_valid (output, 1) and recv_ready (input, 1), the user host-to-device byte stream.
REQ-013 The block SHALL have ports tx_level (output, TX_ASIZE+1) and rx_level (output, RX_ASIZE+1), the current FIFO occupancies.
REQ-014 The block SHALL have ports rx_overflow (output, 1), a sticky drop flag, and rx_drop_cnt (output, 16), a saturating count of dropped bytes.

Function
REQ-015 A send byte SHALL be written exactly when send_valid and send_ready are both 1; send_ready SHALL be 1 iff tx_level < 2^TX_ASIZE and usb_rstn is 1.
REQ-016 A byte SHALL transfer on the IN side exactly when ep_in_valid and ep_in_ready are both 1; ep_in_data SHALL hold stable while ep_in_valid is 1 and ep_in_ready is 0.
REQ-017 The TX release FSM SHALL have three states: EMPTY, ACCUM and RELEASE.
REQ-018 In EMPTY (tx_level=0), a write SHALL move the FSM to ACCUM, or to RELEASE if FLUSH_THRESH=1.
REQ-019 In ACCUM, the FSM SHALL move to RELEASE when the post-write tx_level is at least FLUSH_THRESH, or when the idle counter reaches IDLE_CYCLES-1 with no write in that cycle.
REQ-020 In RELEASE, the FSM SHALL return to EMPTY on the cycle the last buffered byte is consumed with no write in that cycle; writes during RELEASE SHALL keep the FSM in RELEASE.
REQ-021 The idle counter SHALL be cleared on every send write and in EMPTY and RELEASE, increment by 1 each cycle in ACCUM, and never wrap.
REQ-022 ep_in_valid SHALL be 0 in EMPTY and ACCUM.
REQ-023 In RELEASE, ep_in_valid SHALL be 1 whenever at least one byte is presentable.
REQ-024 The IN output stage SHALL be registered and present back-to-back bytes without bubbles while ep_in_ready=1 and data remains.
REQ-025 The first ep_in_valid after entry to RELEASE SHALL occur at most 2 cycles after the entry.
REQ-026 tx_level SHALL count bytes written and not yet consumed, including any byte held in the output register.
REQ-027 A simultaneous send write and IN consume SHALL leave tx_level unchanged; pointers SHALL wrap modulo 2^TX_ASIZE, with an extra MSB for full/empty discrimination.
REQ-028 An OUT byte SHALL be written to the RX FIFO when ep_out_valid=1 and rx_level < 2^RX_ASIZE, where the full test uses the pre-cycle level.
REQ-029 When the RX FIFO is full, an OUT byte SHALL be dropped even if recv consumes a byte in the same cycle.
REQ-030 Each dropped OUT byte SHALL set rx_overflow and increment rx_drop_cnt, which saturates at 16'hFFFF.
REQ-031 recv_valid SHALL be 1 iff rx_level > 0, with recv_data from a registered stage; a byte is consumed on recv_valid and recv_ready both 1.
REQ-032 The write-to-recv_valid latency SHALL be at most 2 cycles.
REQ-033 Simultaneous RX write and read SHALL leave rx_level unchanged.
REQ-034 clr_stats=1 SHALL clear rx_overflow and rx_drop_cnt next cycle; a drop in the same cycle SHALL take priority, leaving rx_overflow=1 and rx_drop_cnt=1.

Reset
REQ-035 rst=1 SHALL, at the next clk edge, empty both FIFOs and put the FSM in EMPTY.
REQ-036 rst=1 SHALL clear the idle counter and the output registers.
REQ-037 After rst, the outputs SHALL be ep_in_valid=0, recv_valid=0, tx_level=0, rx_level=0, rx_overflow=0, rx_drop_cnt=0, and ep_in_data=recv_data=8'h00.
REQ-038 usb_rstn=0, sampled synchronously, SHALL flush both FIFOs, the FSM, the idle counter and the output stages exactly as rst does, and drive send_ready=0.
REQ-039 usb_rstn=0 SHALL preserve rx_overflow and rx_drop_cnt.
REQ-040 A flush mid-packet SHALL discard the unsent bytes, and none SHALL appear on ep_in_* after usb_rstn returns to 1.
REQ-041 Buffer RAM contents SHALL need no reset.

Verification
REQ-042 The bench SHALL cover: defaults, write 5 bytes 0x01..0x05, ep_in_ready=1 -> ep_in_valid stays 0 for 59999 idle cycles, then 0x01..0x05 are delivered in order, tx_level=0, FSM returns to EMPTY.
REQ-043 The bench SHALL cover: 32 back-to-back writes -> RELEASE is entered on the 32nd write, with no idle wait.
REQ-044 The bench SHALL cover: ep_in_ready=0, write until send_ready=0 -> exactly 1024 bytes are accepted and tx_level=1024.
REQ-045 The bench SHALL cover: RX with recv_ready=0, 70 OUT bytes at RX_ASIZE=6 -> rx_level=64, rx_overflow=1, rx_drop_cnt=6; then drain -> the first 64 bytes arrive in order.
REQ-046 The bench SHALL cover: usb_rstn low for 1 cycle mid-RELEASE with 20 bytes pending -> tx_level=0, ep_in_valid=0 and rx_drop_cnt is unchanged.
REQ-047 The bench SHALL cover: clr_stats coincident with a drop -> rx_overflow=1 and rx_drop_cnt=1.
